// File: rtl/counter_run_controller.sv
// Command-driven up-counter sequencer: accepts a limit and mode via valid/ready, then counts
// qualified ticks to the limit in one-shot or auto-reload mode with pause and abort.
module counter_run_controller #(
    parameter int unsigned N      = 4,
    parameter int unsigned WRAP_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [N-1:0]      cmd_limit,
    input  logic              cmd_reload,
    input  logic              tick,
    input  logic              pause,
    input  logic              abort,
    output logic [N-1:0]      q,
    output logic              busy,
    output logic              done,
    output logic [WRAP_W-1:0] wraps
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [N-1:0]        limit_q, limit_d;
    logic                reload_q, reload_d;
    logic [N-1:0]        q_q, q_d;
    logic                done_q, done_d;
    logic [WRAP_W-1:0]   wraps_q, wraps_d;
    logic [N-1:0]        q_inc;
    logic                qual;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            limit_q  <= '0;
            reload_q <= 1'b0;
            q_q      <= '0;
            done_q   <= 1'b0;
            wraps_q  <= '0;
        end else begin
            state_q  <= state_d;
            limit_q  <= limit_d;
            reload_q <= reload_d;
            q_q      <= q_d;
            done_q   <= done_d;
            wraps_q  <= wraps_d;
        end
    end

    assign q_inc = q_q + N'(1);
    assign qual  = tick & ~pause & ~abort & (state_q == StRun);

    always_comb begin
        state_d  = state_q;
        limit_d  = limit_q;
        reload_d = reload_q;
        q_d      = q_q;
        done_d   = 1'b0;
        wraps_d  = wraps_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    limit_d  = cmd_limit;
                    // A zero limit can never wrap, so it always behaves as one-shot.
                    reload_d = cmd_reload & (cmd_limit != '0);
                    q_d      = '0;
                    wraps_d  = '0;
                    if (cmd_limit == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    q_d     = '0;
                end else if (qual) begin
                    if (q_q < limit_q) begin
                        q_d = q_inc;
                        if (q_inc == limit_q) begin
                            done_d = 1'b1;
                            if (!reload_q) begin
                                state_d = StDone;
                            end
                        end
                    end else begin
                        q_d = '0;
                        if (wraps_q != '1) begin
                            wraps_d = wraps_q + WRAP_W'(1);
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                if (abort) begin
                    q_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        q         = q_q;
        done      = done_q;
        wraps     = wraps_q;
    end

endmodule
